// File: rtl/max7219_chain.sv
// Purpose: cascade driver for NUM_DEVICES MAX7219 controllers: power-up init, per-device framebuffer, frame refresh.
// Latency: 1 + (32*NUM_DEVICES + 2)*CLK_DIV clk_in cycles per transaction; a frame is 8 back-to-back transactions.
// Backpressure: none; framebuffer writes always land, refresh requests while busy coalesce into one pending frame.
//
// Ports:
//   clk_in, reset_in (async, active high)
//   fb_we_in/fb_addr_in/fb_data_in : framebuffer write, addr = device*8 + row
//   intensity_in                   : brightness, sampled when the init intensity word is loaded
//   refresh_in                     : one-cycle frame request
//   clk_out/data_out/latch_out     : serial CLK/DIN/LOAD pins
//   busy_out, init_done_out, frame_done_out : status
module max7219_chain #(
  parameter int NUM_DEVICES  = 1,
  parameter int CLK_DIV      = 100,
  parameter int SCAN_LIMIT   = 7,
  parameter int AUTO_REFRESH = 0,
  localparam int AW = (NUM_DEVICES > 1) ? $clog2(8 * NUM_DEVICES) : 3
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          fb_we_in,
  input  logic [AW-1:0] fb_addr_in,
  input  logic [7:0]    fb_data_in,
  input  logic [3:0]    intensity_in,
  input  logic          refresh_in,
  output logic          clk_out,
  output logic          data_out,
  output logic          latch_out,
  output logic          busy_out,
  output logic          init_done_out,
  output logic          frame_done_out
);

  localparam int unsigned FB_DEPTH = 8 * NUM_DEVICES;
  localparam int SW = 16 * NUM_DEVICES;
  localparam int BW = $clog2(SW);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_WORD, BIT_LOW, BIT_HIGH, LATCH, GAP} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div_cnt, div_cnt_nx;
  logic [BW-1:0] bit_cnt, bit_cnt_nx;
  logic [SW-1:0] shreg, shreg_nx;
  logic [2:0]    idx, idx_nx;          // init word index 0..4 or frame row 0..7
  logic          in_frame, in_frame_nx;
  logic          pending, pending_nx;
  logic          init_done_nx, frame_done_nx;
  logic [15:0]   init_cmd;
  logic [SW-1:0] word;
  logic          div_last;

  logic [7:0] fb [FB_DEPTH];

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < int'(FB_DEPTH); i++) fb[i] <= 8'h00;
    end else if (fb_we_in && (32'(fb_addr_in) < FB_DEPTH)) begin
      fb[fb_addr_in] <= fb_data_in;
    end
  end

  always_comb begin
    init_cmd = 16'h0000;
    case (idx)
      3'd0:    init_cmd = 16'h0C01;
      3'd1:    init_cmd = 16'h0F00;
      3'd2:    init_cmd = 16'h0900;
      3'd3:    init_cmd = {8'h0B, 8'(SCAN_LIMIT)};
      default: init_cmd = {8'h0A, 4'h0, intensity_in};
    endcase
  end

  // Device NUM_DEVICES-1 sits in the top bits so it is shifted out first.
  always_comb begin
    word = '0;
    for (int d = 0; d < NUM_DEVICES; d++) begin
      if (in_frame)
        word[16*d +: 16] = {4'h0, {1'b0, idx} + 4'd1, fb[AW'(d * 8) + AW'(idx)]};
      else
        word[16*d +: 16] = init_cmd;
    end
  end

  assign div_last = (div_cnt == DW'(CLK_DIV - 1));

  always_comb begin
    state_nx      = state;
    div_cnt_nx    = div_cnt;
    bit_cnt_nx    = bit_cnt;
    shreg_nx      = shreg;
    idx_nx        = idx;
    in_frame_nx   = in_frame;
    pending_nx    = pending;
    init_done_nx  = init_done_out;
    frame_done_nx = 1'b0;

    if (refresh_in && (state != IDLE)) pending_nx = 1'b1;

    case (state)
      IDLE: begin
        if (!init_done_out) begin
          in_frame_nx = 1'b0;
          idx_nx      = 3'd0;
          state_nx    = LOAD_WORD;
        end else if (refresh_in || pending) begin
          in_frame_nx = 1'b1;
          idx_nx      = 3'd0;
          pending_nx  = 1'b0;
          state_nx    = LOAD_WORD;
        end
      end
      LOAD_WORD: begin
        shreg_nx   = word;
        div_cnt_nx = '0;
        bit_cnt_nx = '0;
        state_nx   = BIT_LOW;
      end
      BIT_LOW: begin
        if (div_last) begin
          div_cnt_nx = '0;
          state_nx   = BIT_HIGH;
        end else begin
          div_cnt_nx = div_cnt + 1'b1;
        end
      end
      BIT_HIGH: begin
        if (div_last) begin
          div_cnt_nx = '0;
          if (bit_cnt == BW'(SW - 1)) begin
            state_nx = LATCH;
          end else begin
            // Shift only after the high phase so DIN is stable across the rising edge.
            bit_cnt_nx = bit_cnt + 1'b1;
            shreg_nx   = {shreg[SW-2:0], 1'b0};
            state_nx   = BIT_LOW;
          end
        end else begin
          div_cnt_nx = div_cnt + 1'b1;
        end
      end
      LATCH: begin
        if (div_last) begin
          div_cnt_nx = '0;
          state_nx   = GAP;
        end else begin
          div_cnt_nx = div_cnt + 1'b1;
        end
      end
      GAP: begin
        if (div_last) begin
          div_cnt_nx = '0;
          state_nx   = LOAD_WORD;
          if (!in_frame) begin
            if (idx == 3'd4) begin
              // Post-init frame also serves any refresh seen during init.
              init_done_nx = 1'b1;
              in_frame_nx  = 1'b1;
              idx_nx       = 3'd0;
              pending_nx   = 1'b0;
            end else begin
              idx_nx = idx + 3'd1;
            end
          end else if (idx == 3'd7) begin
            frame_done_nx = 1'b1;
            idx_nx        = 3'd0;
            if (pending || refresh_in || (AUTO_REFRESH != 0))
              pending_nx = 1'b0;
            else
              state_nx = IDLE;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end else begin
          div_cnt_nx = div_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pin outputs are registered from next-state values so they line up with state and never glitch.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      idx            <= 3'd0;
      in_frame       <= 1'b0;
      pending        <= 1'b0;
      init_done_out  <= 1'b0;
      frame_done_out <= 1'b0;
      clk_out        <= 1'b0;
      data_out       <= 1'b0;
      latch_out      <= 1'b0;
    end else begin
      state          <= state_nx;
      div_cnt        <= div_cnt_nx;
      bit_cnt        <= bit_cnt_nx;
      shreg          <= shreg_nx;
      idx            <= idx_nx;
      in_frame       <= in_frame_nx;
      pending        <= pending_nx;
      init_done_out  <= init_done_nx;
      frame_done_out <= frame_done_nx;
      clk_out        <= (state_nx == BIT_HIGH);
      data_out       <= ((state_nx == BIT_LOW) || (state_nx == BIT_HIGH)) && shreg_nx[SW-1];
      latch_out      <= (state_nx == LATCH);
    end
  end

  assign busy_out = (state != IDLE);

endmodule
